// File: rtl/apb_pkg.sv
// Shared APB definitions: bus width, master FSM states and slave register map.
package apb_pkg;

    localparam int APB_W    = 32;
    localparam int NUM_REGS = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam logic [APB_W-1:0] ADDR_NUMBER  = 32'h0000_0000;
    localparam logic [APB_W-1:0] ADDR_DATE    = 32'h0000_0004;
    localparam logic [APB_W-1:0] ADDR_SURNAME = 32'h0000_0008;
    localparam logic [APB_W-1:0] ADDR_NAME    = 32'h0000_000C;

endpackage

// File: rtl/apb_if.sv
// APB bus bundle shared between the master and the register slave.
interface apb_if;
    import apb_pkg::*;

    logic             PSEL;
    logic             PENABLE;
    logic             PWRITE;
    logic [APB_W-1:0] PADDR;
    logic [APB_W-1:0] PWDATA;
    logic [APB_W-1:0] PRDATA;
    logic             PREADY;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );

endinterface

// File: rtl/apb_slave.sv
// Four-register APB slave, zero wait states, combinational read path.
module apb_slave
    import apb_pkg::*;
(
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             PSEL,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [APB_W-1:0] PADDR,
    input  logic [APB_W-1:0] PWDATA,
    output logic [APB_W-1:0] PRDATA,
    output logic             PREADY
);

    logic [APB_W-1:0] regs_reg [NUM_REGS] = '{default: '0};
    logic             hit;
    logic [1:0]       sel;

    // Full-width compare: anything outside the four aligned words is unmapped.
    always_comb begin
        hit = 1'b0;
        sel = 2'd0;
        case (PADDR)
            ADDR_NUMBER:  begin hit = 1'b1; sel = 2'd0; end
            ADDR_DATE:    begin hit = 1'b1; sel = 2'd1; end
            ADDR_SURNAME: begin hit = 1'b1; sel = 2'd2; end
            ADDR_NAME:    begin hit = 1'b1; sel = 2'd3; end
            default:      begin hit = 1'b0; sel = 2'd0; end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (PSEL && PENABLE && PWRITE && hit) begin
            regs_reg[sel] <= PWDATA;
        end
    end

    assign PREADY = PSEL & PENABLE;
    assign PRDATA = (PSEL && !PWRITE && hit) ? regs_reg[sel] : '0;

endmodule

// File: rtl/apb_master.sv
// Free-running APB master: samples the request on every SETUP entry and
// cycles SETUP/ACCESS back to back, capturing read data on completion.
module apb_master
    import apb_pkg::*;
(
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             PWRITE_MASTER,
    input  logic [APB_W-1:0] PADDR_MASTER,
    input  logic [APB_W-1:0] PWDATA_MASTER,
    output logic [APB_W-1:0] PRDATA_MASTER,
    output logic             PSEL,
    output logic             PENABLE,
    output logic             PWRITE,
    output logic [APB_W-1:0] PADDR,
    output logic [APB_W-1:0] PWDATA,
    input  logic [APB_W-1:0] PRDATA,
    input  logic             PREADY
);

    apb_state_e       state_reg  = IDLE;
    apb_state_e       state_next;
    logic             pwrite_reg = 1'b0;
    logic [APB_W-1:0] paddr_reg  = '0;
    logic [APB_W-1:0] pwdata_reg = '0;
    logic [APB_W-1:0] prdata_reg = '0;
    logic             psel_next;
    logic             penable_next;

    always_comb begin
        state_next   = state_reg;
        psel_next    = 1'b0;
        penable_next = 1'b0;
        case (state_reg)
            IDLE: begin
                state_next = SETUP;
            end
            SETUP: begin
                psel_next  = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                psel_next    = 1'b1;
                penable_next = 1'b1;
                state_next   = PREADY ? SETUP : ACCESS;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_reg  <= IDLE;
            pwrite_reg <= 1'b0;
            paddr_reg  <= '0;
            pwdata_reg <= '0;
            prdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            // Request is sampled only when a new transfer begins; held through ACCESS.
            if (state_next == SETUP) begin
                pwrite_reg <= PWRITE_MASTER;
                paddr_reg  <= PADDR_MASTER;
                pwdata_reg <= PWDATA_MASTER;
            end
            if (state_reg == ACCESS && PREADY && !pwrite_reg) begin
                prdata_reg <= PRDATA;
            end
        end
    end

    assign PSEL          = psel_next;
    assign PENABLE       = penable_next;
    assign PWRITE        = pwrite_reg;
    assign PADDR         = paddr_reg;
    assign PWDATA        = pwdata_reg;
    assign PRDATA_MASTER = prdata_reg;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master + apb_slave: directed table, reset abort, random traffic vs. a register model.
module tb_apb_master;
    import apb_pkg::*;

    logic        PCLK          = 1'b0;
    logic        PRESET        = 1'b1;
    logic        PWRITE_MASTER = 1'b1;
    logic [31:0] PADDR_MASTER  = 32'h8000_0000;
    logic [31:0] PWDATA_MASTER = 32'h0;
    logic [31:0] PRDATA_MASTER;
    logic        stall         = 1'b0;
    logic        slv_pready;

    apb_if bus();
    assign bus.PREADY = slv_pready & ~stall;

    always #5 PCLK = ~PCLK;

    apb_master dut (
        .PCLK          (PCLK),
        .PRESET        (PRESET),
        .PWRITE_MASTER (PWRITE_MASTER),
        .PADDR_MASTER  (PADDR_MASTER),
        .PWDATA_MASTER (PWDATA_MASTER),
        .PRDATA_MASTER (PRDATA_MASTER),
        .PSEL          (bus.PSEL),
        .PENABLE       (bus.PENABLE),
        .PWRITE        (bus.PWRITE),
        .PADDR         (bus.PADDR),
        .PWDATA        (bus.PWDATA),
        .PRDATA        (bus.PRDATA),
        .PREADY        (bus.PREADY)
    );

    apb_slave slv (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (bus.PSEL),
        .PENABLE (bus.PENABLE),
        .PWRITE  (bus.PWRITE),
        .PADDR   (bus.PADDR),
        .PWDATA  (bus.PWDATA),
        .PRDATA  (bus.PRDATA),
        .PREADY  (slv_pready)
    );

    int total = 0;
    int bad   = 0;
    int n_xfer = 0;

    // Reference model: the four registers as seen from the bus, and the last read result.
    logic [31:0] mem [4];
    logic [31:0] exp_prd;

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] data;
        int          nwait;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int map_idx(input logic [31:0] a);
        if (a < 32'd16 && (a % 4) == 0) return int'(a / 4);
        return -1;
    endfunction

    task automatic model_apply(input logic w, input logic [31:0] a, input logic [31:0] d);
        int idx;
        idx = map_idx(a);
        if (w) begin
            if (idx >= 0) mem[idx] = d;
        end else begin
            exp_prd = (idx >= 0) ? mem[idx] : 32'h0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mem[i] = 32'h0;
        exp_prd = 32'h0;
    endtask

    // Unmapped write used as filler between transfers: it never changes the model.
    task automatic drive_filler();
        PWRITE_MASTER = 1'b1;
        PADDR_MASTER  = 32'h8000_0000 | $urandom;
        PWDATA_MASTER = $urandom;
    endtask

    // Entry: next edge enters SETUP. Exit: same condition, after one filler transfer.
    task automatic do_xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input int nwait);
        logic [31:0] prev;
        prev = exp_prd;
        PWRITE_MASTER = w;
        PADDR_MASTER  = a;
        PWDATA_MASTER = d;
        @(posedge PCLK); #1;
        chk("setup_psel",    32'(bus.PSEL),    32'd1);
        chk("setup_penable", 32'(bus.PENABLE), 32'd0);
        chk("setup_paddr",   bus.PADDR,        a);
        chk("setup_pwrite",  32'(bus.PWRITE),  32'(w));
        chk("setup_pwdata",  bus.PWDATA,       d);
        drive_filler();
        stall = (nwait > 0);
        @(posedge PCLK); #1;
        for (int k = 0; k <= nwait; k++) begin
            if (k == nwait) stall = 1'b0;
            chk("access_psel",    32'(bus.PSEL),    32'd1);
            chk("access_penable", 32'(bus.PENABLE), 32'd1);
            chk("access_paddr",   bus.PADDR,        a);
            chk("access_pwrite",  32'(bus.PWRITE),  32'(w));
            chk("access_pwdata",  bus.PWDATA,       d);
            chk("access_prdata_hold", PRDATA_MASTER, prev);
            if (k < nwait) begin
                @(posedge PCLK); #1;
            end
        end
        model_apply(w, a, d);
        @(posedge PCLK); #1;
        chk("done_prdata",  PRDATA_MASTER,     exp_prd);
        chk("next_setup_psel",    32'(bus.PSEL),    32'd1);
        chk("next_setup_penable", 32'(bus.PENABLE), 32'd0);
        @(posedge PCLK); #1;
        n_xfer++;
        $display("xfer %0d %s addr=%h wdata=%h waits=%0d prdata_master=%h",
                 n_xfer, w ? "WR" : "RD", a, d, nwait, PRDATA_MASTER);
    endtask

    initial begin
        model_reset();

        tbl[0]  = '{1'b1, 32'h0,  32'd19,         0, 32'h0};
        tbl[1]  = '{1'b0, 32'h0,  32'h0,          0, 32'h0000_0013};
        tbl[2]  = '{1'b1, 32'h4,  32'h2412_2023,  0, 32'h0000_0013};
        tbl[3]  = '{1'b1, 32'h8,  32'hCFEE_F6E5,  0, 32'h0000_0013};
        tbl[4]  = '{1'b1, 32'hC,  32'hC2EE_E2E0,  0, 32'h0000_0013};
        tbl[5]  = '{1'b0, 32'h4,  32'h0,          0, 32'h2412_2023};
        tbl[6]  = '{1'b0, 32'h8,  32'h0,          0, 32'hCFEE_F6E5};
        tbl[7]  = '{1'b0, 32'hC,  32'h0,          0, 32'hC2EE_E2E0};
        tbl[8]  = '{1'b0, 32'h10, 32'h0,          0, 32'h0};
        tbl[9]  = '{1'b0, 32'h2,  32'h0,          0, 32'h0};
        tbl[10] = '{1'b1, 32'h10, 32'h0000_DEAD,  0, 32'h0};
        tbl[11] = '{1'b1, 32'h6,  32'h0000_BEEF,  0, 32'h0};
        tbl[12] = '{1'b0, 32'h0,  32'h0,          3, 32'h0000_0013};
        tbl[13] = '{1'b1, 32'h8,  32'h1111_1111,  3, 32'h0000_0013};
        tbl[14] = '{1'b0, 32'h8,  32'h0,          0, 32'h1111_1111};

        // Initial values before any clock edge.
        #1;
        chk("init_psel",    32'(bus.PSEL),    32'd0);
        chk("init_penable", 32'(bus.PENABLE), 32'd0);
        chk("init_paddr",   bus.PADDR,        32'h0);
        chk("init_prdata",  PRDATA_MASTER,    32'h0);

        @(posedge PCLK); @(posedge PCLK); #1;
        chk("rst_psel",    32'(bus.PSEL),    32'd0);
        chk("rst_penable", 32'(bus.PENABLE), 32'd0);
        chk("rst_pwrite",  32'(bus.PWRITE),  32'd0);

        PRESET = 1'b0;
        @(posedge PCLK); #1;
        chk("first_setup_psel",    32'(bus.PSEL),    32'd1);
        chk("first_setup_penable", 32'(bus.PENABLE), 32'd0);
        @(posedge PCLK); #1;
        chk("first_access_penable", 32'(bus.PENABLE), 32'd1);

        for (int i = 0; i < 15; i++) begin
            do_xfer(tbl[i].w, tbl[i].addr, tbl[i].data, tbl[i].nwait);
            chk("tbl_prdata", PRDATA_MASTER, tbl[i].exp);
        end

        // Reset during the ACCESS phase of a write to 0x4.
        PWRITE_MASTER = 1'b1;
        PADDR_MASTER  = 32'h4;
        PWDATA_MASTER = 32'hA5A5_5A5A;
        @(posedge PCLK); #1;
        chk("abort_setup_psel", 32'(bus.PSEL), 32'd1);
        @(posedge PCLK); #1;
        chk("abort_access_penable", 32'(bus.PENABLE), 32'd1);
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        model_reset();
        chk("abort_psel",    32'(bus.PSEL),    32'd0);
        chk("abort_penable", 32'(bus.PENABLE), 32'd0);
        chk("abort_paddr",   bus.PADDR,        32'h0);
        chk("abort_prdata",  PRDATA_MASTER,    32'h0);
        drive_filler();
        PRESET = 1'b0;
        @(posedge PCLK); #1;
        chk("release_setup_psel",    32'(bus.PSEL),    32'd1);
        chk("release_setup_penable", 32'(bus.PENABLE), 32'd0);
        @(posedge PCLK); #1;
        chk("release_access_penable", 32'(bus.PENABLE), 32'd1);
        do_xfer(1'b0, 32'h4, 32'h0, 0);
        chk("abort_reg_date", PRDATA_MASTER, 32'h0);

        // Random traffic against the register model.
        for (int n = 0; n < 40; n++) begin
            int          s;
            logic [31:0] a;
            s = $urandom_range(0, 5);
            if (s < 4)       a = 32'(s * 4);
            else if (s == 4) a = 32'h10 + 32'(4 * $urandom_range(0, 3));
            else             a = 32'(4 * $urandom_range(0, 3) + $urandom_range(1, 3));
            do_xfer(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master (delivered with companion register slave apb_slave)

Interface
REQ-001 apb_master SHALL have one clock and a synchronous, active-high reset.
REQ-002 apb_master ports SHALL be, one per line as name, direction, width, meaning:
- PCLK  in  1  clock; all state changes on the rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PWRITE_MASTER  in  1  request direction: 1 = write, 0 = read.
- PADDR_MASTER  in  32  request address.
- PWDATA_MASTER  in  32  request write data.
- PRDATA_MASTER  out  32  last completed read data.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR, PWDATA  out  32 each  APB address and write data.
- PRDATA  in  32  read data from the slave.
- PREADY  in  1  slave transfer-complete flag.
REQ-003 apb_slave ports SHALL be:
- PCLK  in  1
- PRESET  in  1  synchronous, active-high reset.
- PSEL, PENABLE, PWRITE  in  1 each
- PADDR, PWDATA  in  32 each
- PRDATA  out  32
- PREADY  out  1

Function
REQ-004 The master SHALL implement the FSM IDLE -> SETUP -> ACCESS -> SETUP..., issuing transfers continuously with no start strobe.
REQ-005 The master SHALL leave IDLE for SETUP on the first clock edge with PRESET low.
REQ-006 On every edge that enters SETUP, the master SHALL register PADDR_MASTER, PWDATA_MASTER and PWRITE_MASTER into PADDR, PWDATA and PWRITE.
REQ-007 PADDR, PWDATA and PWRITE SHALL then hold stable through the following ACCESS cycle.
REQ-008 Signal values per state:
- IDLE: PSEL=0, PENABLE=0.
- SETUP: PSEL=1, PENABLE=0.
- ACCESS: PSEL=1, PENABLE=1.
REQ-009 From ACCESS, the master SHALL go to SETUP when PREADY=1 and stay in ACCESS while PREADY=0 (wait states, outputs frozen).
REQ-010 An error-free transfer SHALL take exactly 2 PCLK cycles; a request held for 2 edges SHALL be issued exactly once.
REQ-011 PRDATA_MASTER SHALL load PRDATA on the edge that completes a read ACCESS (PREADY=1, PWRITE=0).
REQ-012 PRDATA_MASTER SHALL hold its value across writes and wait states.
REQ-013 The slave SHALL contain four 32-bit registers:
- 0x0 number_in_group
- 0x4 date
- 0x8 surname
- 0xC name
REQ-014 Address decode SHALL require PADDR[31:4]=0 and PADDR[1:0]=0; PADDR[3:2] selects the register.
REQ-015 The slave SHALL write PWDATA into the selected register on the edge where PSEL & PENABLE & PWRITE are all 1.
REQ-016 Writes to unmapped addresses SHALL be ignored.
REQ-017 PREADY SHALL be combinational: PSEL & PENABLE (zero wait states).
REQ-018 PRDATA SHALL be combinational: the selected register when PSEL=1 and PWRITE=0, otherwise 0; unmapped reads SHALL return 0.
REQ-019 A read of an address in the same transfer pair as a write to that address SHALL return the newly written value.

Reset
REQ-020 On an edge with PRESET=1, the master SHALL enter IDLE and zero PSEL, PENABLE, PWRITE, PADDR, PWDATA and PRDATA_MASTER.
REQ-021 On an edge with PRESET=1, the slave SHALL clear all four registers to 0.
REQ-022 Reset asserted mid-transfer SHALL abort the transfer: no register write, and PRDATA_MASTER cleared.
REQ-023 All registers SHALL also carry these reset values as simulation initial values, because a bench may never pulse PRESET.

Structure
REQ-024 A shared package apb_pkg SHALL hold:
- the FSM state enum (IDLE, SETUP, ACCESS);
- the register address constants (0x0, 0x4, 0x8, 0xC);
- the data and address width parameter (32).
REQ-025 apb_master and apb_slave SHALL be separate modules connected at the top level.
REQ-026 The slave register file SHALL stay inside apb_slave; no further sub-modules are required.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Write 19 @0x0, then read 0x0 -> PRDATA_MASTER=0x00000013, each transfer 2 cycles.
- Write 0x24122023 @0x4, 0xCFEEF6E5 @0x8, 0xC2EEE2E0 @0xC; read back in order -> the same values.
- Read 0x10 or 0x2 -> PRDATA_MASTER=0; registers unchanged.
- Force PREADY low for 3 cycles -> master held in ACCESS, outputs stable, completes on the PREADY rise.
- PRESET=1 during ACCESS of a write to 0x4 -> register stays 0, master in IDLE, SETUP one edge after release.
- Phase check on every transfer -> PSEL=1/PENABLE=0 for exactly one cycle, then PENABLE=1 until PREADY.
